shift_loader: RTL
=================

# shift_loader

Upstream sequencer for the 4-bit shift/rotate register. It accepts a parallel word over a valid/ready handshake and serialises it MSB-first onto the register's `Sr_En`/`In` pins. It then releases `Sr_En` so the register free-runs its Johnson rotate for a programmed number of cycles, and flags completion. It also keeps a cycle-accurate mirror of the downstream register contents for checking.

## Interface
- `WIDTH`, default 4: word width; equals the downstream register width.
- `ROT_CYCLES`, default 8: rotate cycles after a load; 0 is legal.
- `CLK` input 1: sole clock, rising edge.
- `CLR` input 1: reset, synchronous, active-low.
- `Data` input WIDTH: word to load; sampled on accept.
- `Valid` input 1: `Data` offered.
- `Abort` input 1: cancel the current load or rotate.
- `Ready` output 1: block can accept a word.
- `Sr_En` output 1: drives downstream `Sr_En`; registered.
- `In` output 1: drives downstream `In`; registered.
- `Busy` output 1: state is not IDLE.
- `Done` output 1: one-cycle pulse when a sequence completes normally.
- `Mirror` output WIDTH: expected downstream `q` after every edge.

## Operation
- States are IDLE, SHIFT and ROTATE.
- **IDLE**
  - `Ready`=1, `Sr_En`=0, `In`=0.
  - Accept happens on an edge with `Valid`&`Ready`&~`Abort`. On accept: latch `Data`, bit counter ← 0, go to SHIFT.
- **SHIFT**
  - `Sr_En`=1.
  - `In` = `word[WIDTH-1-k]` in shift cycle k (k = 0..WIDTH-1).
  - After WIDTH cycles: go to ROTATE if `ROT_CYCLES`>0, else go to IDLE with `Done`.
- **ROTATE**
  - `Sr_En`=0, `In`=0. The downstream register performs `q ← {q[WIDTH-2:0], ~q[WIDTH-1]}`.
  - After `ROT_CYCLES` cycles: go to IDLE, with `Done`=1 in the first IDLE cycle.
- **Abort**
  - Applies in SHIFT or ROTATE: next cycle is IDLE, no `Done`, latched word discarded.
  - Applies in IDLE: blocks accept.
  - Abort has priority over `Valid`.
- **Back-to-back:** `Ready`=1 in the same cycle as `Done`. An accept in that cycle starts a new SHIFT on the following cycle.
- **Mirror**
  - Updates every edge: `Mirror ← {Mirror[WIDTH-2:0], Sr_En ? In : ~Mirror[WIDTH-1]}`, using the registered `Sr_En`/`In` values present during the cycle.
  - The downstream register keeps rotating in IDLE; `Mirror` tracks it there too.
- **Counters:** rotate counter width is `$clog2(ROT_CYCLES+1)`, minimum 1; bit counter width is `$clog2(WIDTH)`. Neither counter may wrap.
- **Reset** (`CLR`=0 at an edge):
  - State IDLE; `Sr_En`=0, `In`=0, `Done`=0, `Busy`=0, `Ready`=1, `Mirror`=0, counters 0.
  - Applies mid-sequence as well.
  - The downstream register must be cleared in the same cycle for `Mirror` to stay valid.

## Timing
- Accept at edge E0.
  - SHIFT occupies cycles E0+1 .. E0+WIDTH.
  - After edge E0+WIDTH, `Mirror` == latched `Data`.
- ROTATE occupies the following `ROT_CYCLES` cycles.
- `Done` is high for exactly one cycle, starting at edge E0+WIDTH+`ROT_CYCLES`.
- Total accept-to-`Done` latency is WIDTH+`ROT_CYCLES` cycles; throughput is one word per WIDTH+`ROT_CYCLES` cycles.
- All outputs are registered. `Ready` is a function of state only; it has no combinational path from `Valid`.

## Structure
- Package `shift_loader_pkg` holds:
  - the state enum `{IDLE, SHIFT, ROTATE}`;
  - `DEF_WIDTH`=4;
  - `DEF_ROT_CYCLES`=8.
- Sub-module `shift_rotate_model`: the `Mirror` update logic. It is reused by the downstream register's bench as its reference model.

## Test plan
1. Reset, then 5 idle cycles with `Valid`=0 → `Mirror` = 0001, 0011, 0111, 1111, 1110; `Busy`=0 throughout.
2. Load `Data`=1010, `ROT_CYCLES`=8 → `In` = 1,0,1,0 with `Sr_En`=1 for 4 cycles; `Mirror`=1010 after 4 cycles; `Mirror` sequence 0100, 1001, 0010, 0101, 1011, 0110, 1101, 1010; `Done` on cycle 12 with `Mirror`=1010.
3. Load 1100 immediately followed by 0011, `Valid` held high → second accept in the `Done` cycle, no idle gap; `Mirror`=0011 four cycles later.
4. `Abort` during the 2nd SHIFT cycle of 1111 → IDLE the next cycle, `Done` never pulses, `Sr_En`=0; a `Valid` offered together with `Abort` in IDLE is not accepted.
5. `CLR`=0 during ROTATE → next cycle `Mirror`=0000, `Busy`=0, `Ready`=1, `Sr_En`=0.
6. `ROT_CYCLES`=0, load 0110 → `Done` 4 cycles after accept, `Mirror`=0110 in that cycle.

Source files
------------

// File: rtl/shift_loader_pkg.sv
// Shared types and defaults for the shift_loader sequencer and its mirror model.
package shift_loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      ROTATE = 2'd2
   } state_t;

   localparam int DEF_WIDTH      = 4;
   localparam int DEF_ROT_CYCLES = 8;

   // Counter width for holding values up to n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/shift_loader_shift_rotate_model.sv
// Cycle-accurate model of the downstream 4-bit shift/rotate register.
// Shifts In when Sr_En is high, otherwise performs a Johnson rotate.
module shift_rotate_model
   import shift_loader_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             Sr_En,
   input  logic             In,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_reg;
   logic             feed;

   assign feed = Sr_En ? In : ~q_reg[WIDTH-1];
   assign q    = q_reg;

   // Register contents: cleared on reset, otherwise shift the feed bit in at the LSB.
   always_ff @(posedge CLK) begin
      if (!CLR) begin
         q_reg <= '0;
      end else begin
         q_reg <= (q_reg << 1) | WIDTH'(feed);
      end
   end

endmodule

// File: rtl/shift_loader.sv
// Loads a parallel word MSB-first into the downstream shift/rotate register,
// lets it rotate for ROT_CYCLES cycles, then pulses Done. Mirror tracks the
// downstream register contents edge by edge.
module shift_loader
   import shift_loader_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ROT_CYCLES = DEF_ROT_CYCLES
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic [WIDTH-1:0] Data,
   input  logic             Valid,
   input  logic             Abort,
   output logic             Ready,
   output logic             Sr_En,
   output logic             In,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Mirror
);

   localparam int BW = cnt_width(WIDTH);
   localparam int RW = cnt_width(ROT_CYCLES + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   // Rotate counter counts down from ROT_CYCLES to 1 so it never needs ROT_CYCLES-1.
   localparam logic [RW-1:0] ROT_LOAD = RW'(ROT_CYCLES);
   localparam logic [RW-1:0] ROT_LAST = RW'(1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] word_reg, word_next;
   logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
   logic [RW-1:0]    rot_cnt_reg, rot_cnt_next;
   logic             sr_en_reg, sr_en_next;
   logic             in_reg, in_next;
   logic             done_reg, done_next;
   logic             accept;
   logic [WIDTH-1:0] word_shifted;

   // Abort outranks Valid; Ready depends on state alone.
   assign accept       = Valid && (state_reg == IDLE) && !Abort;
   // The latched word is shifted left each cycle so its MSB is always the next bit out.
   assign word_shifted = word_reg << 1;

   assign Ready = (state_reg == IDLE);
   assign Busy  = (state_reg != IDLE);
   assign Sr_En = sr_en_reg;
   assign In    = in_reg;
   assign Done  = done_reg;

   // State and registered-output update.
   always_ff @(posedge CLK) begin
      if (!CLR) begin
         state_reg   <= IDLE;
         word_reg    <= '0;
         bit_cnt_reg <= '0;
         rot_cnt_reg <= '0;
         sr_en_reg   <= 1'b0;
         in_reg      <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         word_reg    <= word_next;
         bit_cnt_reg <= bit_cnt_next;
         rot_cnt_reg <= rot_cnt_next;
         sr_en_reg   <= sr_en_next;
         in_reg      <= in_next;
         done_reg    <= done_next;
      end
   end

   // Next-state and next-output logic; Sr_En/In/Done fall back to 0 unless set.
   always_comb begin
      state_next   = state_reg;
      word_next    = word_reg;
      bit_cnt_next = bit_cnt_reg;
      rot_cnt_next = rot_cnt_reg;
      sr_en_next   = 1'b0;
      in_next      = 1'b0;
      done_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               word_next    = Data;
               bit_cnt_next = '0;
               state_next   = SHIFT;
               sr_en_next   = 1'b1;
               in_next      = Data[WIDTH-1];
            end
         end
         SHIFT: begin
            if (Abort) begin
               state_next   = IDLE;
               word_next    = '0;
               bit_cnt_next = '0;
            end else if (bit_cnt_reg == BIT_LAST) begin
               bit_cnt_next = '0;
               word_next    = '0;
               if (ROT_CYCLES > 0) begin
                  state_next   = ROTATE;
                  rot_cnt_next = ROT_LOAD;
               end else begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end else begin
               bit_cnt_next = bit_cnt_reg + BW'(1);
               word_next    = word_shifted;
               sr_en_next   = 1'b1;
               in_next      = word_shifted[WIDTH-1];
            end
         end
         ROTATE: begin
            if (Abort) begin
               state_next   = IDLE;
               rot_cnt_next = '0;
            end else if (rot_cnt_reg == ROT_LAST) begin
               state_next   = IDLE;
               rot_cnt_next = '0;
               done_next    = 1'b1;
            end else begin
               rot_cnt_next = rot_cnt_reg - RW'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   shift_rotate_model #(
      .WIDTH(WIDTH)
   ) u_model (
      .CLK  (CLK),
      .CLR  (CLR),
      .Sr_En(sr_en_reg),
      .In   (in_reg),
      .q    (Mirror)
   );

endmodule
